// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer register block.
// Holds the FSM state type, default bus widths and the word-index helper.
package apb_pkg;

   typedef enum logic {APB_IDLE, APB_ACCESS} apb_cs_state_e;

   localparam int APB_DATA_W = 32;
   localparam int APB_ADDR_W = 8;

   function automatic int unsigned word_idx(input logic [31:0] addr);
      return addr >> 2;
   endfunction

endpackage

// File: rtl/apb_regfile.sv
// Byte-strobed register bank with one async read port.
// Word 0 is a read-only constant; no bus protocol logic lives here.
module apb_regfile #(
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 16,
   parameter int                IW       = 4,
   parameter logic [DATA_W-1:0] ID_VALUE = 32'hA5B0_0001
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [IW-1:0]       widx,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [IW-1:0]       ridx,
   output logic [DATA_W-1:0]   rdata
);

   localparam int STRB_W = DATA_W / 8;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) begin
               mem_q[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   always_comb begin
      rdata = mem_q[ridx];
      if (ridx == '0) begin
         rdata = ID_VALUE;
      end
   end

endmodule

// File: rtl/apb_completer_regs.sv
// APB4 completer in front of a byte-strobed register bank.
// Two-state FSM with optional wait states, error decode and protocol checks.
module apb_completer_regs
   import apb_pkg::*;
#(
   parameter int                ADDR_W      = APB_ADDR_W,
   parameter int                DATA_W      = APB_DATA_W,
   parameter int                DEPTH       = 16,
   parameter int                WAIT_STATES = 0,
   parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
   input  logic                pclk,
   input  logic                preset,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
   input  logic [DATA_W/8-1:0] pstrb,
   output logic [DATA_W-1:0]   prdata,
   output logic                pready,
   output logic                pslverr,
   output logic                proto_err
);

   localparam int          STRB_W  = DATA_W / 8;
   localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CNT_W   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam int unsigned DEPTH_U = DEPTH;

   apb_cs_state_e state_q, state_d;

   logic [CNT_W-1:0]  wcnt_q;
   logic [IW-1:0]     addr_q;
   logic              write_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] strb_q;
   logic              err_q;
   logic [DATA_W-1:0] prdata_q;
   logic              proto_q;

   int unsigned       idx;
   logic              acc_err;
   logic              in_acc;
   logic              latch;
   logic              complete;
   logic              viol;
   logic              we;
   logic [DATA_W-1:0] rf_rdata;

   assign idx     = word_idx(32'(paddr));
   assign acc_err = (paddr[1:0] != 2'b00) | (idx >= DEPTH_U) | (pwrite & (idx == 0));
   assign in_acc  = (state_q == APB_ACCESS);

   // A SETUP seen during ACCESS restarts the transfer with fresh latches.
   assign latch    = psel & ~penable;
   assign complete = in_acc & psel & penable & pready;
   assign viol     = (~in_acc & psel & penable) | (in_acc & ~psel) | (in_acc & psel & ~penable);
   assign we       = complete & write_q & ~err_q;

   always_ff @(posedge pclk) begin
      if (!preset) begin
         state_q <= APB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         APB_IDLE: begin
            if (psel && !penable) state_d = APB_ACCESS;
         end
         APB_ACCESS: begin
            if (!psel) state_d = APB_IDLE;
            else if (penable && pready) state_d = APB_IDLE;
         end
         default: state_d = APB_IDLE;
      endcase
   end

   always_comb begin
      pready  = in_acc & (wcnt_q == CNT_W'(WAIT_STATES));
      pslverr = err_q & pready;
   end

   always_ff @(posedge pclk) begin
      if (!preset) begin
         wcnt_q   <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         strb_q   <= '0;
         err_q    <= 1'b0;
         prdata_q <= '0;
         proto_q  <= 1'b0;
      end else begin
         proto_q <= viol;
         if (latch) begin
            wcnt_q  <= '0;
            addr_q  <= IW'(idx);
            write_q <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            err_q   <= acc_err;
            if (!pwrite) begin
               prdata_q <= acc_err ? '0 : rf_rdata;
            end
         end else if (state_d == APB_IDLE) begin
            wcnt_q <= '0;
         end else if (!pready) begin
            wcnt_q <= wcnt_q + CNT_W'(1);
         end
      end
   end

   assign prdata    = prdata_q;
   assign proto_err = proto_q;

   apb_regfile #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .IW       (IW),
      .ID_VALUE (ID_VALUE)
   ) u_regfile (
      .clk   (pclk),
      .rst_n (preset),
      .we    (we),
      .widx  (addr_q),
      .wstrb (strb_q),
      .wdata (wdata_q),
      .ridx  (IW'(idx)),
      .rdata (rf_rdata)
   );

endmodule

// File: tb/tb_apb_completer_regs.sv
// Bench for apb_completer_regs: three instances with 0, 3 and 2 wait states.
module tb_apb_completer_regs;

   localparam logic [31:0] ID = 32'hA5B0_0001;

   logic        pclk = 1'b0;
   logic        preset;
   logic [2:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata [3];
   logic        pready [3];
   logic        pslverr [3];
   logic        perr [3];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 pclk = ~pclk;

   apb_completer_regs #(.WAIT_STATES(0)) u_ws0 (
      .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
      .proto_err(perr[0]));

   apb_completer_regs #(.WAIT_STATES(3)) u_ws3 (
      .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
      .proto_err(perr[1]));

   apb_completer_regs #(.WAIT_STATES(2)) u_ws2 (
      .pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]),
      .proto_err(perr[2]));

   typedef struct {
      int          dut;
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
      bit          exp_err;
      int          exp_waits;
   } vec_t;

   typedef struct {
      string       name;
      bit          wr;
      logic [31:0] rd;
      bit          err;
      int          waits;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // Starts at #1 after an edge; leaves the bus idle at #1 after the completing edge.
   task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rd, output logic err,
                       output int waits, output bit ok);
      psel    = '0;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = wd;
      pstrb   = st;
      tick();
      penable = 1'b1;
      waits   = 0;
      ok      = 1'b0;
      rd      = '0;
      err     = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (pready[d]) begin
            rd  = prdata[d];
            err = pslverr[d];
            ok  = 1'b1;
            break;
         end
         waits++;
         tick();
      end
      tick();
      psel    = '0;
      penable = 1'b0;
   endtask

   task automatic run(input vec_t v, input string name);
      exp_t        e;
      logic [31:0] rd;
      logic        err;
      int          w;
      bit          ok;
      sb.push_back('{name, v.wr, v.exp_rd, v.exp_err, v.exp_waits});
      xfer(v.dut, v.wr, v.addr, v.data, v.strb, rd, err, w, ok);
      e = sb.pop_front();
      check({e.name, "_done"}, 32'(ok), 32'd1);
      check({e.name, "_err"}, 32'(err), 32'(e.err));
      check({e.name, "_waits"}, w, e.waits);
      if (!e.wr) check({e.name, "_rdata"}, rd, e.rd);
   endtask

   vec_t vt[$];

   initial begin
      vec_t v;
      vt = '{
         '{0, 1'b0, 8'h00, 32'h0,         4'h0, ID,            1'b0, 0},
         '{0, 1'b1, 8'h04, 32'hDEAD_BEEF, 4'h5, 32'h0,         1'b0, 0},
         '{0, 1'b0, 8'h04, 32'h0,         4'h0, 32'h00AD_00EF, 1'b0, 0},
         '{0, 1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1, 0},
         '{0, 1'b0, 8'h00, 32'h0,         4'h0, ID,            1'b0, 0},
         '{0, 1'b0, 8'h06, 32'h0,         4'h0, 32'h0,         1'b1, 0},
         '{0, 1'b0, 8'h40, 32'h0,         4'h0, 32'h0,         1'b1, 0},
         '{0, 1'b1, 8'h04, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0, 0},
         '{0, 1'b0, 8'h04, 32'h0,         4'hF, 32'h00AD_00EF, 1'b0, 0},
         '{0, 1'b1, 8'h3C, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0, 0},
         '{0, 1'b0, 8'h3C, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 0},
         '{0, 1'b1, 8'h05, 32'h1111_1111, 4'hF, 32'h0,         1'b1, 0},
         '{1, 1'b1, 8'h08, 32'h1234_5678, 4'hF, 32'h0,         1'b0, 3},
         '{1, 1'b0, 8'h08, 32'h0,         4'h0, 32'h1234_5678, 1'b0, 3},
         '{1, 1'b0, 8'h44, 32'h0,         4'h0, 32'h0,         1'b1, 3}
      };

      psel    = '0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      preset  = 1'b0;
      tick();
      tick();
      preset = 1'b1;

      check("rst_pready", 32'(pready[0]), 32'd0);
      check("rst_pslverr", 32'(pslverr[0]), 32'd0);
      check("rst_prdata", prdata[0], 32'h0);
      check("rst_proto", 32'(perr[0]), 32'd0);

      foreach (vt[i]) run(vt[i], $sformatf("vec%0d", i));

      // Enable asserted together with select while idle.
      tick();
      psel[0] = 1'b1;
      penable = 1'b1;
      tick();
      check("idle_viol_proto", 32'(perr[0]), 32'd1);
      check("idle_viol_pready", 32'(pready[0]), 32'd0);
      psel    = '0;
      penable = 1'b0;
      tick();
      check("idle_viol_pulse", 32'(perr[0]), 32'd0);

      // Select dropped in the middle of a waited write.
      psel[2] = 1'b1;
      pwrite  = 1'b1;
      paddr   = 8'h0C;
      pwdata  = 32'h5555_AAAA;
      pstrb   = 4'hF;
      tick();
      penable = 1'b1;
      tick();
      check("drop_wait_pready", 32'(pready[2]), 32'd0);
      psel    = '0;
      penable = 1'b0;
      tick();
      check("drop_proto", 32'(perr[2]), 32'd1);
      check("drop_pready", 32'(pready[2]), 32'd0);
      tick();
      check("drop_pulse", 32'(perr[2]), 32'd0);
      v = '{2, 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0, 1'b0, 2};
      run(v, "drop_readback");

      // Reset landing inside the access phase of a write.
      v = '{1, 1'b1, 8'h10, 32'h7777_7777, 4'hF, 32'h0, 1'b0, 3};
      run(v, "pre_rst_wr");
      psel[1] = 1'b1;
      pwrite  = 1'b1;
      paddr   = 8'h0C;
      pwdata  = 32'hBEEF_0001;
      pstrb   = 4'hF;
      tick();
      penable = 1'b1;
      tick();
      preset = 1'b0;
      tick();
      check("mid_rst_pready", 32'(pready[1]), 32'd0);
      preset  = 1'b1;
      psel    = '0;
      penable = 1'b0;
      tick();
      for (int w = 0; w < 16; w++) begin
         v = '{1, 1'b0, 8'(w * 4), 32'h0, 4'h0, (w == 0) ? ID : 32'h0, 1'b0, 3};
         run(v, $sformatf("post_rst_w%0d", w));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
